// File: rtl/ram4002_responder.sv
// ram4002_responder: RAM-side responder for the MCS-4 data bus.
//
// Tracks the eight-subcycle instruction cycle (A1..X3) from SYNC and the
// phase strobes, latches SRC addresses and executes RAM I/O opcodes gated by
// CM-RAM. Holds 4 registers x (16 main + 4 status) nibbles and drives read
// data onto the bus for the whole X2 subcycle.
//
// Optional feature: define RAM4002_OUTPUT_PORT_EN to build the output port
// latch written by WMP. When it is undefined, port_out is tied to zero and
// WMP does nothing.
//
// Ports:
//   sysclk    in   system clock, the only clock
//   poc_n     in   asynchronous active-low reset
//   clk1      in   phase-1 strobe; qualifies data_in capture
//   clk2      in   phase-2 strobe; its falling edge advances the subcycle
//   sync      in   SYNC from the CPU, high during X3
//   cm_ram    in   CM-RAM select for this bank
//   data_in   in   bus nibble as seen at the pins
//   data_out  out  nibble to drive (zero when not driving)
//   data_oe   out  bus drive enable
//   port_out  out  output port latch
module ram4002_responder #(
  parameter logic [1:0] CHIP_ID = 2'd0
) (
  input  logic       sysclk,
  input  logic       poc_n,
  input  logic       clk1,
  input  logic       clk2,
  input  logic       sync,
  input  logic       cm_ram,
  input  logic [3:0] data_in,
  output logic [3:0] data_out,
  output logic       data_oe,
  output logic [3:0] port_out
);

  typedef enum logic [3:0] {
    StUnsync, StA1, StA2, StA3, StM1, StM2, StX1, StX2, StX3
  } state_e;

  state_e     state_q, state_d;
  logic       clk2_q;
  logic [3:0] din_q;
  logic [3:0] opa_q, opa_d;
  logic       io_pend_q, io_pend_d;
  logic       src_pend_q, src_pend_d;
  logic       sel_q, sel_d;
  logic [1:0] reg_q, reg_d;
  logic [3:0] chr_q, chr_d;
  logic       adv;
  logic       main_we, stat_we;

  logic [3:0] main_q [4][16];
  logic [3:0] stat_q [4][4];

  assign adv = clk2_q & ~clk2;

  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      clk2_q     <= 1'b0;
      din_q      <= 4'h0;
      state_q    <= StUnsync;
      opa_q      <= 4'h0;
      io_pend_q  <= 1'b0;
      src_pend_q <= 1'b0;
      sel_q      <= 1'b0;
      reg_q      <= 2'd0;
      chr_q      <= 4'h0;
    end else begin
      clk2_q <= clk2;
      // Bus value is only trusted while phase 1 is asserted; held until adv.
      if (clk1) din_q <= data_in;
      state_q    <= state_d;
      opa_q      <= opa_d;
      io_pend_q  <= io_pend_d;
      src_pend_q <= src_pend_d;
      sel_q      <= sel_d;
      reg_q      <= reg_d;
      chr_q      <= chr_d;
    end
  end

`ifdef RAM4002_OUTPUT_PORT_EN
  logic       port_we;
  logic [3:0] port_q;

  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n)       port_q <= 4'h0;
    else if (port_we) port_q <= din_q;
  end

  assign port_out = port_q;
`else
  assign port_out = 4'h0;
`endif

  always_comb begin
    state_d    = state_q;
    opa_d      = opa_q;
    io_pend_d  = io_pend_q;
    src_pend_d = src_pend_q;
    sel_d      = sel_q;
    reg_d      = reg_q;
    chr_d      = chr_q;
    main_we    = 1'b0;
    stat_we    = 1'b0;
`ifdef RAM4002_OUTPUT_PORT_EN
    port_we    = 1'b0;
`endif
    if (adv) begin
      if (sync && state_q != StX3) begin
        // Resync: realign to A1 and drop any half-finished transaction.
        state_d    = StA1;
        io_pend_d  = 1'b0;
        src_pend_d = 1'b0;
      end else begin
        unique case (state_q)
          StUnsync: state_d = StUnsync;
          StA1:     state_d = StA2;
          StA2:     state_d = StA3;
          StA3:     state_d = StM1;
          StM1:     state_d = StM2;
          StM2: begin
            state_d   = StX1;
            io_pend_d = cm_ram;
            if (cm_ram) opa_d = din_q;
          end
          StX1:     state_d = StX2;
          StX2: begin
            state_d = StX3;
            if (io_pend_q && sel_q) begin
              unique case (opa_q)
                4'h0: main_we = 1'b1;
`ifdef RAM4002_OUTPUT_PORT_EN
                4'h1: port_we = 1'b1;
`endif
                4'h4, 4'h5, 4'h6, 4'h7: stat_we = 1'b1;
                default: ;
              endcase
            end
            // SRC high nibble; suppressed when an I/O op owns this X2.
            if (!io_pend_q && cm_ram) begin
              sel_d      = (din_q[3:2] == CHIP_ID);
              reg_d      = din_q[1:0];
              src_pend_d = 1'b1;
            end
          end
          StX3: begin
            state_d = StA1;
            if (src_pend_q) begin
              chr_d      = din_q;
              src_pend_d = 1'b0;
            end
          end
          default: state_d = StUnsync;
        endcase
      end
    end
  end

  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 16; j++) main_q[i][j] <= 4'h0;
        for (int j = 0; j < 4; j++)  stat_q[i][j] <= 4'h0;
      end
    end else begin
      if (main_we) main_q[reg_q][chr_q] <= din_q;
      if (stat_we) stat_q[reg_q][opa_q[1:0]] <= din_q;
    end
  end

  logic rd_main, rd_stat;

  always_comb begin
    rd_main  = (opa_q == 4'h8) || (opa_q == 4'h9) || (opa_q == 4'hB);
    rd_stat  = (opa_q[3:2] == 2'b11);
    data_oe  = (state_q == StX2) && io_pend_q && sel_q && (rd_main || rd_stat);
    data_out = 4'h0;
    if (data_oe) begin
      data_out = rd_main ? main_q[reg_q][chr_q] : stat_q[reg_q][opa_q[1:0]];
    end
  end

endmodule

// File: tb/tb_ram4002_responder.sv
// Bench for ram4002_responder with CHIP_ID=2. Each instruction cycle is one
// table record; the expected X2 bus state is queued as the cycle is driven
// and compared when the DUT reaches X2. Other subcycles must not drive.
module tb_ram4002_responder;

  logic       sysclk = 1'b0;
  logic       poc_n, clk1, clk2, sync, cm_ram;
  logic [3:0] data_in, data_out, port_out;
  logic       data_oe;

  int total = 0;
  int bad   = 0;

  always #5 sysclk = ~sysclk;

  ram4002_responder #(.CHIP_ID(2'd2)) dut (
    .sysclk   (sysclk),
    .poc_n    (poc_n),
    .clk1     (clk1),
    .clk2     (clk2),
    .sync     (sync),
    .cm_ram   (cm_ram),
    .data_in  (data_in),
    .data_out (data_out),
    .data_oe  (data_oe),
    .port_out (port_out)
  );

  typedef struct {
    string      name;
    logic [3:0] m2;
    logic       m2cm;
    logic [3:0] x2;
    logic       x2cm;
    logic [3:0] x3;
    logic       oe;
    logic [3:0] dout;
  } vec_t;

  vec_t       vecs[$];
  logic [4:0] exp_q[$];

  function automatic vec_t mk(input string n, input logic [3:0] m2, input logic m2cm,
                              input logic [3:0] x2, input logic x2cm, input logic [3:0] x3,
                              input logic oe, input logic [3:0] d);
    vec_t v;
    v.name = n; v.m2 = m2; v.m2cm = m2cm; v.x2 = x2; v.x2cm = x2cm; v.x3 = x3;
    v.oe = oe; v.dout = d;
    return v;
  endfunction

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got {oe,data}=%h want %h", name, act, exp);
    end
  endtask

  // One subcycle: sample the bus for the current state, then present the
  // nibble, strobe clk1, then clk2; clk2 falling ends the subcycle.
  task automatic sub(input logic [3:0] d, input logic cm, input logic s, input logic score,
                     input string name);
    logic [4:0] e;
    @(negedge sysclk);
    if (score) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL %s: scoreboard empty", name);
      end else begin
        e = exp_q.pop_front();
        chk(name, {data_oe, data_out}, e);
      end
    end else begin
      chk({name, "/idle"}, {data_oe, data_out}, 5'h00);
    end
    data_in = d; cm_ram = cm; sync = s; clk1 = 1'b1;
    @(negedge sysclk) clk1 = 1'b0;
    @(negedge sysclk) clk2 = 1'b1;
    @(negedge sysclk) clk2 = 1'b0;
  endtask

  // A1..X1 of a cycle, leaving the DUT about to enter X2.
  task automatic head(input vec_t v);
    sub(4'h0, 1'b0, 1'b0, 1'b0, {v.name, "/A1"});
    sub(4'h0, 1'b0, 1'b0, 1'b0, {v.name, "/A2"});
    sub(4'h0, 1'b0, 1'b0, 1'b0, {v.name, "/A3"});
    sub(4'h0, 1'b0, 1'b0, 1'b0, {v.name, "/M1"});
    sub(v.m2, v.m2cm, 1'b0, 1'b0, {v.name, "/M2"});
  endtask

  task automatic cycle(input vec_t v);
    head(v);
    sub(4'h0, 1'b0, 1'b0, 1'b0, {v.name, "/X1"});
    exp_q.push_back({v.oe, v.dout});
    sub(v.x2, v.x2cm, 1'b0, 1'b1, {v.name, "/X2"});
    sub(v.x3, 1'b0, 1'b1, 1'b0, {v.name, "/X3"});
  endtask

  logic [3:0] port_exp;

  initial begin
    poc_n = 1'b0; clk1 = 1'b0; clk2 = 1'b0; sync = 1'b0; cm_ram = 1'b0; data_in = 4'h0;

    vecs.push_back(mk("src1",      4'h0, 0, 4'h9, 1, 4'h7, 0, 4'h0));
    vecs.push_back(mk("wrm_a",     4'h0, 1, 4'hA, 0, 4'h0, 0, 4'h0));
    vecs.push_back(mk("rdm_a",     4'h9, 1, 4'h0, 0, 4'h0, 1, 4'hA));
    vecs.push_back(mk("nocm",      4'h9, 0, 4'h0, 0, 4'h0, 0, 4'h0));
    vecs.push_back(mk("src_mis",   4'h0, 0, 4'h5, 1, 4'h7, 0, 4'h0));
    vecs.push_back(mk("rdm_mis",   4'h9, 1, 4'h0, 0, 4'h0, 0, 4'h0));
    vecs.push_back(mk("wrm_mis",   4'h0, 1, 4'h5, 0, 4'h0, 0, 4'h0));
    vecs.push_back(mk("src_re",    4'h0, 0, 4'h9, 1, 4'h7, 0, 4'h0));
    vecs.push_back(mk("rdm_keep",  4'h9, 1, 4'h0, 0, 4'h0, 1, 4'hA));
    vecs.push_back(mk("src_r3",    4'h0, 0, 4'hB, 1, 4'h2, 0, 4'h0));
    vecs.push_back(mk("wr2",       4'h6, 1, 4'hC, 0, 4'h0, 0, 4'h0));
    vecs.push_back(mk("rd2",       4'hE, 1, 4'h0, 0, 4'h0, 1, 4'hC));
    vecs.push_back(mk("rd1",       4'hD, 1, 4'h0, 0, 4'h0, 1, 4'h0));
    vecs.push_back(mk("op2",       4'h2, 1, 4'hF, 0, 4'h0, 0, 4'h0));
    vecs.push_back(mk("op3",       4'h3, 1, 4'hF, 0, 4'h0, 0, 4'h0));
    vecs.push_back(mk("opA",       4'hA, 1, 4'hF, 0, 4'h0, 0, 4'h0));
    vecs.push_back(mk("rd2_b",     4'hE, 1, 4'h0, 0, 4'h0, 1, 4'hC));
    vecs.push_back(mk("rdm_r3",    4'h9, 1, 4'h0, 0, 4'h0, 1, 4'h0));
    vecs.push_back(mk("sbm",       4'h8, 1, 4'h0, 0, 4'h0, 1, 4'h0));
    vecs.push_back(mk("wrm_3",     4'h0, 1, 4'h3, 0, 4'h0, 0, 4'h0));
    vecs.push_back(mk("adm",       4'hB, 1, 4'h0, 0, 4'h0, 1, 4'h3));
    vecs.push_back(mk("rdm_rep",   4'h9, 1, 4'h0, 0, 4'h0, 1, 4'h3));
    vecs.push_back(mk("illegal",   4'h9, 1, 4'h1, 1, 4'h5, 1, 4'h3));
    vecs.push_back(mk("after_ill", 4'h9, 1, 4'h0, 0, 4'h0, 1, 4'h3));
    vecs.push_back(mk("wmp",       4'h1, 1, 4'h6, 0, 4'h0, 0, 4'h0));

    // Reset state.
    #23;
    chk("rst_bus", {data_oe, data_out}, 5'h00);
    chk("rst_port", {1'b0, port_out}, 5'h00);
    @(negedge sysclk) poc_n = 1'b1;

    // Two cycles without SYNC: FSM stays unsynchronised, nothing driven.
    for (int c = 0; c < 2; c++) begin
      sub(4'h0, 1'b0, 1'b0, 1'b0, "unsync");
      sub(4'h0, 1'b0, 1'b0, 1'b0, "unsync");
      sub(4'h0, 1'b0, 1'b0, 1'b0, "unsync");
      sub(4'h0, 1'b0, 1'b0, 1'b0, "unsync");
      sub(4'h9, 1'b1, 1'b0, 1'b0, "unsync");
      sub(4'h0, 1'b0, 1'b0, 1'b0, "unsync");
      sub(4'h9, 1'b1, 1'b0, 1'b0, "unsync");
      sub(4'h7, 1'b0, 1'b0, 1'b0, "unsync");
    end
    sub(4'h0, 1'b0, 1'b1, 1'b0, "first_sync");

    foreach (vecs[i]) cycle(vecs[i]);

`ifdef RAM4002_OUTPUT_PORT_EN
    port_exp = 4'h6;
`else
    port_exp = 4'h0;
`endif
    chk("port_out", {1'b0, port_out}, {1'b0, port_exp});

    // Resync at X1: next subcycle must be A1, not X2.
    head(mk("resync", 4'h9, 1, 4'h0, 0, 4'h0, 0, 4'h0));
    sub(4'h0, 1'b0, 1'b1, 1'b0, "resync/X1");
    cycle(mk("post_resync", 4'h9, 1, 4'h0, 0, 4'h0, 1, 4'h3));

    // Reset pulse in the middle of an RDM's X2.
    head(mk("rst_mid", 4'h9, 1, 4'h0, 0, 4'h0, 0, 4'h0));
    sub(4'h0, 1'b0, 1'b0, 1'b0, "rst_mid/X1");
    @(negedge sysclk);
    chk("rst_mid/pre", {data_oe, data_out}, 5'h13);
    #2 poc_n = 1'b0;
    #1;
    chk("rst_mid/async", {data_oe, data_out}, 5'h00);
    chk("rst_mid/port", {1'b0, port_out}, 5'h00);
    @(negedge sysclk);
    poc_n = 1'b1; clk1 = 1'b0; clk2 = 1'b0; sync = 1'b0; cm_ram = 1'b0;
    for (int k = 0; k < 8; k++) sub(4'h9, 1'b1, 1'b0, 1'b0, "post_rst");
    sub(4'h0, 1'b0, 1'b1, 1'b0, "post_rst_sync");
    cycle(mk("src_r3_b", 4'h0, 0, 4'hB, 1, 4'h2, 0, 4'h0));
    cycle(mk("rdm_clr",  4'h9, 1, 4'h0, 0, 4'h0, 1, 4'h0));
    cycle(mk("rd2_clr",  4'hE, 1, 4'h0, 0, 4'h0, 1, 4'h0));

    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram4002_responder.md
Name: ram4002_responder

Overview:
- Data-bus responder for the MCS-4 bus: the RAM end of the protocol the CPU scratchpad and timing logic drive.
- Tracks the 8-subcycle instruction cycle (A1 A2 A3 M1 M2 X1 X2 X3) from SYNC and the phase strobes.
- Latches SRC addresses and decodes RAM I/O opcodes gated by CM-RAM.
- Stores 4 registers × (16 main + 4 status) nibbles and drives read data onto the bus during X2.

Parameters:
- CHIP_ID, 2'd0, chip number compared against D3..D2 of the SRC high nibble.

Ports:
- sysclk  in  1  FPGA system clock, the only clock.
- poc_n  in  1  asynchronous active-low reset.
- clk1  in  1  phase-1 strobe, sampled on sysclk.
- clk2  in  1  phase-2 strobe, sampled on sysclk.
- sync  in  1  SYNC from CPU, high during X3.
- cm_ram  in  1  CM-RAM select for this bank.
- data_in  in  4  bus value as seen at the pins.
- data_out  out  4  nibble to drive.
- data_oe  out  1  bus drive enable; top level builds the inout.
- port_out  out  4  output port latch.

Behaviour:
- Advance event (adv): sysclk edge where clk2 was registered 1 and is now 0 (clk2 falling).
- Subcycle FSM states: UNSYNC, A1..X3.
  - Reset → UNSYNC.
  - On adv with sync=1, any state → A1.
  - On adv with sync=0: A1→A2→…→X3→A1; UNSYNC stays UNSYNC.
  - No bus activity in UNSYNC.
- Every "end of Sx" action below happens on the adv leaving Sx, using data_in and cm_ram sampled on that edge.
- End of M2:
  - cm_ram=1 → opa<=data_in, io_pend<=1.
  - Else io_pend<=0.
- End of X2 with io_pend=0 and cm_ram=1 (SRC high nibble):
  - sel<=(data_in[3:2]==CHIP_ID), reg<=data_in[1:0], src_pend<=1.
- End of X3 with src_pend=1:
  - chr<=data_in, src_pend<=0.
- Execution requires io_pend=1 and sel=1; it occurs at X2.
- Write opcodes: data captured at end of X2.
  - 0 WRM: main[reg][chr]<=data_in.
  - 1 WMP: port_out<=data_in.
  - 4..7 WR0..WR3: status[reg][opa[1:0]]<=data_in.
- Read opcodes:
  - 8 SBM, 9 RDM, B ADM: data_out=main[reg][chr].
  - C..F RD0..RD3: data_out=status[reg][opa[1:0]].
  - data_oe=1 for the entire X2 state, and 0 everywhere else.
- Opcodes 2, 3, A (ROM/program-memory ops): no response, no state change.
- data_out=0 whenever data_oe=0.
- Reset mid-operation:
  - Immediate asynchronous clear of FSM, opa, io_pend, src_pend, sel, reg, chr, port_out, all main/status nibbles.
  - data_oe=0 during and after reset until the first full resync.
- SYNC arriving in a state other than X3 (resync): FSM → A1; io_pend and src_pend cleared on that adv.
- cm_ram=1 at both M2 and the following X2 (illegal): the I/O executes with the old address, and no SRC capture occurs.
- Address persistence: repeated I/O without a new SRC reuses reg/chr; no auto-increment.
- clk1 is used only to qualify the input: data_in sampled on adv is the value held since the last clk1=1 sysclk edge within the subcycle.

Optional Feature:
- Macro: RAM4002_OUTPUT_PORT_EN.
- Defined: port_out register and WMP behaviour as above.
- Undefined: port_out tied 4'h0, WMP treated as a no-op, register not synthesised.

Test Plan:
- Reset, then two cycles without SYNC → FSM stays UNSYNC, data_oe never 1. Then one SYNC at X3 → next adv enters A1.
- CHIP_ID=2: SRC with X2 nibble 4'b1001, X3 nibble 4'h7; then WRM (cm_ram at M2, opa=0) with data 4'hA at X2; then RDM (opa=9) → data_oe=1 only during X2, data_out=4'hA.
- SRC with chip bits 2'b01 (mismatch); RDM → data_oe stays 0. WRM 4'h5, then reselect the matching chip → main[1][7] still 4'hA.
- WR2 with 4'hC after SRC reg=3 → RD2 returns 4'hC, RD1 returns 4'h0. Opcodes 2/3/A → no drive, no state change.
- WMP 4'h6 → port_out=4'h6 after end of X2 (macro defined), or 4'h0 (macro undefined).
- poc_n pulsed low during X2 of an RDM → data_oe drops asynchronously. After release and resync, RDM at the same address returns 4'h0.
